// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//
// Purpose: shares the single-access general-purpose register file between
// requester 0 (execute/ALU writeback) and requester 1 (load/store unit).
// The arbiter accepts one request at a time with round-robin fairness. It
// drives the register file strobes, select lines and halfword mode, and
// captures the file's registered read data. The result goes back to the
// requester with a one-cycle done pulse. Illegal register indices are
// rejected with an error pulse and never reach the file.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/1, we0/1         request and write-enable per requester
//   half0/1               halfword mode per requester
//   addr0/1, wdata0/1     register index and write data per requester
//   gnt0/1                one-cycle pulse, request accepted
//   done0/1, err0/1       one-cycle completion pulse, error flag with done
//   rdata0/1              read result, held after done
//   busy                  high whenever the arbiter is not IDLE
//   rf_readsig/writesig   register file strobes
//   rf_halfword           register file halfword mode
//   rf_sr, rf_dr          register file read / write select
//   rf_data_write         register file write data
//   rf_data_read          register file read data, one clk after readsig
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int NUM_FULL = 6,
  parameter int NUM_HALF = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              half0,
  input  logic              half1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              rf_readsig,
  output logic              rf_writesig,
  output logic              rf_halfword,
  output logic [ADDR_W-1:0] rf_sr,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [DATA_W-1:0] rf_data_write,
  input  logic [DATA_W-1:0] rf_data_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              winId_q, winId_d;
  logic              isWrite_q, isWrite_d;
  logic              illegal_q, illegal_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              readsig_q, readsig_d, writesig_q, writesig_d;
  logic              halfword_q, halfword_d;
  logic [ADDR_W-1:0] sr_q, sr_d, dr_q, dr_d;
  logic [DATA_W-1:0] dataWrite_q, dataWrite_d;

  logic              selId;
  logic              selWe;
  logic              selHalf;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selLegal;

  // Pick the candidate requester. On a tie the requester that did not win
  // last time gets the grant. The selected fields and their legality feed
  // the IDLE decision below.
  always_comb begin
    selId    = (req0 && req1) ? ~lastGrant_q : req1;
    selWe    = selId ? we1    : we0;
    selHalf  = selId ? half1  : half0;
    selAddr  = selId ? addr1  : addr0;
    selWdata = selId ? wdata1 : wdata0;
    selLegal = selHalf ? (32'(selAddr) < 32'(NUM_HALF))
                       : (32'(selAddr) < 32'(NUM_FULL));
  end

  // Next-state and registered-output logic. Every output is a register, so
  // the strobes for the ISSUE cycle are computed on the edge that accepts
  // the request. Done and err are computed on the edge that enters RESP.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    winId_d     = winId_q;
    isWrite_d   = isWrite_q;
    illegal_d   = illegal_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    readsig_d   = 1'b0;
    writesig_d  = 1'b0;
    halfword_d  = 1'b0;
    sr_d        = '0;
    dr_d        = '0;
    dataWrite_d = '0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = ISSUE;
          lastGrant_d = selId;
          winId_d     = selId;
          isWrite_d   = selWe;
          illegal_d   = ~selLegal;
          gnt0_d      = ~selId;
          gnt1_d      = selId;
          if (selLegal && selWe) begin
            writesig_d  = 1'b1;
            dr_d        = selAddr;
            dataWrite_d = selWdata;
            halfword_d  = selHalf;
          end else if (selLegal) begin
            readsig_d  = 1'b1;
            sr_d       = selAddr;
            halfword_d = selHalf;
          end
        end
      end

      ISSUE: begin
        if (illegal_q || isWrite_q) begin
          state_d = RESP;
          done0_d = ~winId_q;
          done1_d = winId_q;
          err0_d  = illegal_q && ~winId_q;
          err1_d  = illegal_q && winId_q;
          // A rejected read returns zero; a rejected write leaves rdata alone.
          if (illegal_q && !isWrite_q) begin
            if (winId_q) rdata1_d = '0;
            else         rdata0_d = '0;
          end
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        state_d = RESP;
        done0_d = ~winId_q;
        done1_d = winId_q;
        if (winId_q) rdata1_d = rf_data_read;
        else         rdata0_d = rf_data_read;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset abandons any transaction in flight,
  // drops the strobes at once and points the arbiter at requester 1 so
  // that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      winId_q     <= 1'b0;
      isWrite_q   <= 1'b0;
      illegal_q   <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
      readsig_q   <= 1'b0;
      writesig_q  <= 1'b0;
      halfword_q  <= 1'b0;
      sr_q        <= '0;
      dr_q        <= '0;
      dataWrite_q <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      winId_q     <= winId_d;
      isWrite_q   <= isWrite_d;
      illegal_q   <= illegal_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
      readsig_q   <= readsig_d;
      writesig_q  <= writesig_d;
      halfword_q  <= halfword_d;
      sr_q        <= sr_d;
      dr_q        <= dr_d;
      dataWrite_q <= dataWrite_d;
    end
  end

  assign gnt0          = gnt0_q;
  assign gnt1          = gnt1_q;
  assign done0         = done0_q;
  assign done1         = done1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign busy          = busy_q;
  assign rf_readsig    = readsig_q;
  assign rf_writesig   = writesig_q;
  assign rf_halfword   = halfword_q;
  assign rf_sr         = sr_q;
  assign rf_dr         = dr_q;
  assign rf_data_write = dataWrite_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Directed testbench for regfile_arbiter with a scoreboard. Stimulus pushes
// hand-computed expectations (grant, register file strobe, response) into
// queues. Monitors on the falling clock edge pop and compare them whenever
// the DUT presents a grant, a strobe or a done. A small register file stub
// returns registered read data one clock after readsig.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int DW = 20;
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1, half0, half1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic          rf_readsig, rf_writesig, rf_halfword;
  logic [AW-1:0] rf_sr, rf_dr;
  logic [DW-1:0] rf_data_write;
  logic [DW-1:0] rf_data_read;

  typedef struct {
    int id;
    int cyc;
  } gntExp_t;

  typedef struct {
    bit            write;
    bit            half;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } strobeExp_t;

  typedef struct {
    int            id;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } respExp_t;

  gntExp_t    gntQ[$];
  strobeExp_t strobeQ[$];
  respExp_t   respQ[$];

  logic [DW-1:0] rfMem [16];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  regfile_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_FULL(6), .NUM_HALF(12)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .half0(half0), .half1(half1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .rf_readsig(rf_readsig), .rf_writesig(rf_writesig),
    .rf_halfword(rf_halfword), .rf_sr(rf_sr), .rf_dr(rf_dr),
    .rf_data_write(rf_data_write), .rf_data_read(rf_data_read)
  );

  // Free-running clock and a cycle counter bumped on every rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register file stub: read data is registered, writes update the array.
  always @(posedge clk) begin
    if (rf_readsig)  rf_data_read <= rfMem[rf_sr];
    if (rf_writesig) rfMem[rf_dr] <= rf_data_write;
  end

  // Watchdog so a wedged run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h cyc=%0d",
               name, actual, expected, cyc);
    end
  endtask

  // Grant monitor: at most one grant per cycle, matching the scoreboard.
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      checkOutput("gntOneHot", 32'(gnt0 && gnt1), 32'd0);
      if (gntQ.size() == 0) begin
        checkOutput("gntUnexpected", 32'd1, 32'd0);
      end else begin
        gntExp_t e;
        e = gntQ.pop_front();
        checkOutput("gntId", 32'(gnt1), 32'(e.id));
        checkOutput("gntCycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Strobe monitor: strobes, selects and data against the scoreboard.
  // With no strobe active, both selects must read zero.
  always @(negedge clk) begin
    if (rf_readsig || rf_writesig) begin
      checkOutput("strobeOneHot", 32'(rf_readsig && rf_writesig), 32'd0);
      if (strobeQ.size() == 0) begin
        checkOutput("strobeUnexpected", 32'd1, 32'd0);
      end else begin
        strobeExp_t e;
        e = strobeQ.pop_front();
        checkOutput("strobeWrite", 32'(rf_writesig), 32'(e.write));
        checkOutput("strobeHalf", 32'(rf_halfword), 32'(e.half));
        checkOutput("strobeCycle", 32'(cyc), 32'(e.cyc));
        if (e.write) begin
          checkOutput("writeDr", 32'(rf_dr), 32'(e.addr));
          checkOutput("writeSr", 32'(rf_sr), 32'd0);
          checkOutput("writeData", 32'(rf_data_write), 32'(e.data));
        end else begin
          checkOutput("readSr", 32'(rf_sr), 32'(e.addr));
          checkOutput("readDr", 32'(rf_dr), 32'd0);
        end
      end
    end else begin
      checkOutput("idleSelects", 32'({rf_sr, rf_dr}), 32'd0);
    end
  end

  // Response monitor: done, err and the requester's rdata against the
  // scoreboard, including the cycle the response arrives in.
  always @(negedge clk) begin
    if (done0 || done1) begin
      checkOutput("doneOneHot", 32'(done0 && done1), 32'd0);
      if (respQ.size() == 0) begin
        checkOutput("doneUnexpected", 32'd1, 32'd0);
      end else begin
        respExp_t e;
        e = respQ.pop_front();
        checkOutput("doneId", 32'(done1), 32'(e.id));
        checkOutput("doneCycle", 32'(cyc), 32'(e.cyc));
        checkOutput("doneErr", 32'(e.id == 1 ? err1 : err0), 32'(e.err));
        checkOutput("doneRdata", 32'(e.id == 1 ? rdata1 : rdata0),
                    32'(e.rdata));
      end
    end else if (err0 || err1) begin
      checkOutput("errWithoutDone", 32'(err0 || err1), 32'd0);
    end
  end

  task automatic setReq(input int id, input bit req, input bit we,
                        input bit half, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    if (id == 0) begin
      req0 = req; we0 = we; half0 = half; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; half1 = half; addr1 = addr; wdata1 = wdata;
    end
  endtask

  // Queue the expected grant, strobe (legal only) and response for a
  // request sampled on rising edge number sampleCyc.
  task automatic pushTxn(input int id, input bit we, input bit half,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit legal, input logic [DW-1:0] expRd,
                         input int sampleCyc);
    gntQ.push_back('{id: id, cyc: sampleCyc + 1});
    if (legal)
      strobeQ.push_back('{write: we, half: half, addr: addr,
                          data: we ? wdata : '0, cyc: sampleCyc + 1});
    respQ.push_back('{id: id, err: !legal, rdata: expRd,
                      cyc: sampleCyc + ((legal && !we) ? 3 : 2)});
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One isolated transaction. It is called on a falling edge with the DUT
  // idle, drops req right after the grant and scrambles the fields so the
  // latched copies are the ones that count.
  task automatic applyStimulus(input int id, input bit we, input bit half,
                               input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input bit legal,
                               input logic [DW-1:0] expRd);
    int n;
    n = cyc;
    pushTxn(id, we, half, addr, wdata, legal, expRd, n);
    setReq(id, 1'b1, we, half, addr, wdata);
    @(negedge clk);
    setReq(id, 1'b0, ~we, ~half, addr ^ 4'hF, ~wdata);
    waitUntil(n + ((legal && !we) ? 4 : 3));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Pulses"},
                32'({gnt0, gnt1, done0, done1, err0, err1}), 32'd0);
    checkOutput({tag, "Rdata0"}, 32'(rdata0), 32'd0);
    checkOutput({tag, "Rdata1"}, 32'(rdata1), 32'd0);
    checkOutput({tag, "Strobes"},
                32'({rf_readsig, rf_writesig, rf_halfword}), 32'd0);
    checkOutput({tag, "Selects"}, 32'({rf_sr, rf_dr}), 32'd0);
    checkOutput({tag, "WriteData"}, 32'(rf_data_write), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rfMem[i] = '0;
    rfMem[5]  = 20'h0F0F0;
    rfMem[6]  = 20'h00066;
    rfMem[7]  = 20'h003A5;
    rfMem[11] = 20'h00B0B;
    rf_data_read = '0;
    reset = 1'b1;
    setReq(0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    setReq(1, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // Full-word write from requester 0.
    applyStimulus(0, 1'b1, 1'b0, 4'd2, 20'h0ABCD, 1'b1, 20'h00000);

    // Half-word read from requester 1.
    applyStimulus(1, 1'b0, 1'b1, 4'd7, 20'h00000, 1'b1, 20'h003A5);

    // Both requesters held high: grants alternate 0,1,0,1.
    n = cyc;
    setReq(0, 1'b1, 1'b0, 1'b0, 4'd5, 20'h00000);
    setReq(1, 1'b1, 1'b1, 1'b0, 4'd1, 20'h11111);
    pushTxn(0, 1'b0, 1'b0, 4'd5, 20'h0, 1'b1, 20'h0F0F0, n);
    pushTxn(1, 1'b1, 1'b0, 4'd1, 20'h11111, 1'b1, 20'h003A5, n + 4);
    pushTxn(0, 1'b0, 1'b0, 4'd5, 20'h0, 1'b1, 20'h0F0F0, n + 7);
    pushTxn(1, 1'b1, 1'b0, 4'd1, 20'h11111, 1'b1, 20'h003A5, n + 11);
    waitUntil(n + 12);
    setReq(0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    setReq(1, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    waitUntil(n + 15);

    // Illegal indices and the legal boundaries next to them.
    applyStimulus(0, 1'b1, 1'b0, 4'd6,  20'h12345, 1'b0, 20'h0F0F0);
    applyStimulus(1, 1'b0, 1'b1, 4'd12, 20'h00000, 1'b0, 20'h00000);
    applyStimulus(1, 1'b0, 1'b1, 4'd11, 20'h00000, 1'b1, 20'h00B0B);
    applyStimulus(0, 1'b0, 1'b1, 4'd6,  20'h00000, 1'b1, 20'h00066);
    applyStimulus(0, 1'b1, 1'b0, 4'd5,  20'h0CAFE, 1'b1, 20'h00066);

    // Reset while a read sits in CAPTURE: no done. After release, a tie
    // goes to requester 0 first.
    n = cyc;
    gntQ.push_back('{id: 0, cyc: n + 1});
    strobeQ.push_back('{write: 1'b0, half: 1'b0, addr: 4'd3, data: '0,
                        cyc: n + 1});
    setReq(0, 1'b1, 1'b0, 1'b0, 4'd3, 20'h0);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    @(negedge clk);
    reset = 1'b1;
    setReq(0, 1'b1, 1'b1, 1'b0, 4'd4, 20'h04444);
    setReq(1, 1'b1, 1'b1, 1'b0, 4'd0, 20'h00055);
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    reset = 1'b0;
    pushTxn(0, 1'b1, 1'b0, 4'd4, 20'h04444, 1'b1, 20'h0, n + 3);
    pushTxn(1, 1'b1, 1'b0, 4'd0, 20'h00055, 1'b1, 20'h0, n + 6);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    waitUntil(n + 7);
    setReq(1, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    waitUntil(n + 10);

    // Back-to-back writes with req0 held; fields change after the grant.
    n = cyc;
    setReq(0, 1'b1, 1'b1, 1'b0, 4'd0, 20'h00AAA);
    pushTxn(0, 1'b1, 1'b0, 4'd0, 20'h00AAA, 1'b1, 20'h0, n);
    pushTxn(0, 1'b1, 1'b0, 4'd5, 20'h05555, 1'b1, 20'h0, n + 3);
    @(negedge clk);
    checkOutput("busyInIssue", 32'(busy), 32'd1);
    setReq(0, 1'b1, 1'b1, 1'b0, 4'd5, 20'h05555);
    waitUntil(n + 3);
    checkOutput("busyInIdle", 32'(busy), 32'd0);
    waitUntil(n + 4);
    setReq(0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0);
    waitUntil(n + 7);

    checkOutput("gntQueueEmpty", 32'(gntQ.size()), 32'd0);
    checkOutput("strobeQueueEmpty", 32'(strobeQ.size()), 32'd0);
    checkOutput("respQueueEmpty", 32'(respQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single-access general-purpose register file between two requesters: requester 0 (execute/ALU writeback) and requester 1 (load/store unit).
- Latches one request at a time and drives the register file's clk-synchronous read/write strobes, select lines and halfword mode.
- Captures the registered read data and returns it with a one-cycle done pulse.
- Fair round-robin arbitration; illegal register indices are rejected without touching the file.

Parameters:
- DATA_W, 20, register data width.
- ADDR_W, 4, register select width.
- NUM_FULL, 6, legal full-word indices are 0..NUM_FULL-1.
- NUM_HALF, 12, legal half-word indices are 0..NUM_HALF-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1  request from requester 0 / 1.
- we0, we1  in  1  1 = write, 0 = read.
- half0, half1  in  1  halfword mode for the request.
- addr0, addr1  in  ADDR_W  register index.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted.
- done0, done1  out  1  one-cycle pulse: transaction complete.
- err0, err1  out  1  pulses with done when the index was illegal.
- rdata0, rdata1  out  DATA_W  read result, valid while done is high, held afterwards.
- busy  out  1  high in any state other than IDLE.
- rf_readsig, rf_writesig  out  1  register file strobes.
- rf_halfword  out  1  register file halfword mode.
- rf_sr, rf_dr  out  ADDR_W  register file read select / write select.
- rf_data_write  out  DATA_W  register file write data.
- rf_data_read  in  DATA_W  register file read data (registered in the file, one clk after readsig).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0, including rdata0/1.
  - The round-robin pointer last_grant resets to 1, so requester 0 wins the first tie.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> (CAPTURE for a legal read) -> RESP -> IDLE.
- IDLE:
  - req0/req1 are sampled only in IDLE; requests arriving in other states wait.
  - If only one req is high, that requester wins.
  - If both are high, the requester other than last_grant wins.
  - On the winning edge: latch we/half/addr/wdata/id, update last_grant, pulse gnt of the winner for the following cycle, move to ISSUE.
- ISSUE:
  - Legality: full-word requires addr < NUM_FULL; half-word requires addr < NUM_HALF.
  - Legal write: rf_writesig=1, rf_dr=addr, rf_data_write=wdata, rf_halfword=half for exactly this one cycle. Next state is RESP.
  - Legal read: rf_readsig=1, rf_sr=addr, rf_halfword=half for exactly this one cycle. Next state is CAPTURE.
  - Illegal index: no strobe. Next state is RESP with the error flag set.
- CAPTURE:
  - All strobes are 0.
  - rf_data_read is valid; latch it into the winner's rdata.
  - The other requester's rdata is unchanged. Next state is RESP.
- RESP:
  - done of the winner is high for exactly one cycle.
  - err of the winner is high if illegal; in that case rdata of the winner is 0 for a read and unchanged for a write.
  - Next state is IDLE.
- Latency from the sampling edge to done high:
  - Write: done high 2 cycles after the edge that samples req (gnt high 1 cycle after).
  - Read: done high 3 cycles after the sampling edge.
  - A full transaction occupies 3 (write) or 4 (read) cycles including IDLE.
- Handshake:
  - The requester holds req and its fields stable until gnt.
  - Fields may change after gnt; the arbiter uses latched copies.
  - Dropping req after gnt does not abort the transaction.
  - A req still high in the IDLE cycle after done is a new transaction (back-to-back allowed).
- Simultaneous req from the loser: it is served next, unless it drops req before the next IDLE.
- rf_sr and rf_dr are 0 whenever their strobe is 0.
- rf_halfword and rf_data_write are 0 outside ISSUE.
- busy = (state != IDLE).
- Reset mid-transaction: the transaction is abandoned; no done or err is issued; strobes drop immediately.

Test Plan:
- Reset then req0 write full addr=2, wdata=0x0ABCD:
  - gnt0 is high 1 cycle after sampling.
  - rf_writesig=1, rf_dr=2, rf_data_write=0x0ABCD for exactly 1 cycle.
  - done0 is high 2 cycles after sampling; err0=0.
- req1 read half addr=7, model rf_data_read=0x003A5 one cycle after readsig:
  - rf_readsig=1, rf_sr=7, rf_halfword=1.
  - rdata1=0x003A5 with done1, 3 cycles after sampling.
- req0 and req1 both held high continuously after reset:
  - Grants alternate 0,1,0,1.
  - No two gnt or done pulses in the same cycle.
  - No rf strobe while another transaction is in flight.
- Illegal indices: req0 full addr=6, then req1 half addr=12:
  - No rf strobes.
  - done and err pulse together; rdata1=0.
- reset asserted during a read's CAPTURE cycle:
  - All outputs go to 0 immediately; no done.
  - After release, a pending req0 and req1 tie grants req0 first.
- Back-to-back: req0 held high for two writes (addr 0 then 5; fields change after gnt):
  - Two gnt0 pulses 3 cycles apart.
  - Second write uses the new fields.
